// File: rtl/axi4_burst_ptgen.sv
// axi4_burst_ptgen: AXI4 burst pattern generator, writes SEED+index bursts and reads them back for comparison.
// Ports: ACLK/ARESET clock and sync active-high reset; INIT_AXI_TXN rising edge starts a run with MODE/SEED;
// M_AXI_AW*/W*/B*/AR*/R* AXI4 master channels; TXN_DONE run complete, ERROR sticky, ERR_CNT saturating,
// BUSY high outside IDLE/DONE.
module axi4_burst_ptgen #(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                BURST_LEN  = 16,
   parameter int                NUM_BURSTS = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h4000_0000
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                INIT_AXI_TXN,
   input  logic [1:0]          MODE,
   input  logic [DATA_W-1:0]   SEED,
   output logic [ADDR_W-1:0]   M_AXI_AWADDR,
   output logic [7:0]          M_AXI_AWLEN,
   output logic [2:0]          M_AXI_AWSIZE,
   output logic [1:0]          M_AXI_AWBURST,
   output logic                M_AXI_AWVALID,
   input  logic                M_AXI_AWREADY,
   output logic [DATA_W-1:0]   M_AXI_WDATA,
   output logic [DATA_W/8-1:0] M_AXI_WSTRB,
   output logic                M_AXI_WLAST,
   output logic                M_AXI_WVALID,
   input  logic                M_AXI_WREADY,
   input  logic [1:0]          M_AXI_BRESP,
   input  logic                M_AXI_BVALID,
   output logic                M_AXI_BREADY,
   output logic [ADDR_W-1:0]   M_AXI_ARADDR,
   output logic [7:0]          M_AXI_ARLEN,
   output logic [2:0]          M_AXI_ARSIZE,
   output logic [1:0]          M_AXI_ARBURST,
   output logic                M_AXI_ARVALID,
   input  logic                M_AXI_ARREADY,
   input  logic [DATA_W-1:0]   M_AXI_RDATA,
   input  logic [1:0]          M_AXI_RRESP,
   input  logic                M_AXI_RLAST,
   input  logic                M_AXI_RVALID,
   output logic                M_AXI_RREADY,
   output logic                TXN_DONE,
   output logic                ERROR,
   output logic [15:0]         ERR_CNT,
   output logic                BUSY
);
   localparam int BYTES = DATA_W / 8;
   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(BURST_LEN * BYTES);
   typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
   state_t state_q, state_d;
   logic [15:0] bcnt_q, bcnt_d, ecnt_q, ecnt_d;
   logic [8:0] beat_q, beat_d;
   logic [1:0] mode_q, mode_d;
   logic [DATA_W-1:0] seed_q, seed_d, pat;
   logic [ADDR_W-1:0] addr;
   logic init_q, awv_q, awv_d, wv_q, wv_d, arv_q, arv_d, err_q, err_d;
   logic last_beat, last_burst, start, ev;
   assign last_beat  = beat_q == 9'(BURST_LEN - 1);
   assign last_burst = bcnt_q == 16'(NUM_BURSTS - 1);
   assign start      = INIT_AXI_TXN && !init_q && (state_q == IDLE || state_q == DONE);
   assign pat        = seed_q + DATA_W'(bcnt_q) * DATA_W'(BURST_LEN) + DATA_W'(beat_q);
   assign addr       = BASE_ADDR + ADDR_W'(bcnt_q) * STRIDE;
   assign M_AXI_AWADDR  = addr;
   assign M_AXI_ARADDR  = addr;
   assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
   assign M_AXI_ARLEN   = 8'(BURST_LEN - 1);
   assign M_AXI_AWSIZE  = 3'($clog2(BYTES));
   assign M_AXI_ARSIZE  = 3'($clog2(BYTES));
   assign M_AXI_AWBURST = 2'b01;
   assign M_AXI_ARBURST = 2'b01;
   assign M_AXI_AWVALID = awv_q;
   assign M_AXI_WVALID  = wv_q;
   assign M_AXI_ARVALID = arv_q;
   assign M_AXI_WDATA   = pat;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WLAST   = state_q == WR_DATA && last_beat;
   assign M_AXI_BREADY  = state_q == WR_RESP;
   assign M_AXI_RREADY  = state_q == RD_DATA;
   assign TXN_DONE      = state_q == DONE;
   assign BUSY          = !(state_q == IDLE || state_q == DONE);
   assign ERROR         = err_q;
   assign ERR_CNT       = ecnt_q;
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      beat_d  = beat_q;
      mode_d  = mode_q;
      seed_d  = seed_q;
      awv_d   = awv_q;
      wv_d    = wv_q;
      arv_d   = arv_q;
      err_d   = err_q;
      ecnt_d  = ecnt_q;
      ev      = 1'b0;
      case (state_q)
         IDLE, DONE: if (start) begin
            mode_d  = MODE;
            seed_d  = SEED;
            bcnt_d  = '0;
            beat_d  = '0;
            err_d   = 1'b0;
            ecnt_d  = '0;
            state_d = MODE == 2'd2 ? RD_ADDR : WR_ADDR;
         end
         // VALIDs are registered, so they rise the cycle after the state is entered
         WR_ADDR: if (!awv_q) awv_d = 1'b1;
            else if (M_AXI_AWREADY) begin
               awv_d   = 1'b0;
               state_d = WR_DATA;
            end
         WR_DATA: if (!wv_q) wv_d = 1'b1;
            else if (M_AXI_WREADY) begin
               beat_d  = last_beat ? '0 : beat_q + 9'd1;
               wv_d    = !last_beat;
               state_d = last_beat ? WR_RESP : WR_DATA;
            end
         WR_RESP: if (M_AXI_BVALID) begin
            ev      = M_AXI_BRESP != 2'b00;
            bcnt_d  = last_burst ? '0 : bcnt_q + 16'd1;
            state_d = !last_burst ? WR_ADDR : mode_q == 2'd1 ? DONE : RD_ADDR;
         end
         RD_ADDR: if (!arv_q) arv_d = 1'b1;
            else if (M_AXI_ARREADY) begin
               arv_d   = 1'b0;
               state_d = RD_DATA;
            end
         // the burst ends on the beat count, never on RLAST, so a bad RLAST cannot truncate the run
         RD_DATA: if (M_AXI_RVALID) begin
            ev      = M_AXI_RRESP != 2'b00 || M_AXI_RDATA != pat || M_AXI_RLAST != last_beat;
            beat_d  = last_beat ? '0 : beat_q + 9'd1;
            bcnt_d  = last_beat ? bcnt_q + 16'd1 : bcnt_q;
            state_d = !last_beat ? RD_DATA : last_burst ? DONE : RD_ADDR;
         end
         default: state_d = IDLE;
      endcase
      if (ev) begin
         err_d  = 1'b1;
         ecnt_d = ecnt_q == 16'hFFFF ? ecnt_q : ecnt_q + 16'd1;
      end
   end
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= IDLE;
         bcnt_q  <= '0;
         beat_q  <= '0;
         mode_q  <= '0;
         seed_q  <= '0;
         init_q  <= 1'b1;
         awv_q   <= 1'b0;
         wv_q    <= 1'b0;
         arv_q   <= 1'b0;
         err_q   <= 1'b0;
         ecnt_q  <= '0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         beat_q  <= beat_d;
         mode_q  <= mode_d;
         seed_q  <= seed_d;
         init_q  <= INIT_AXI_TXN;
         awv_q   <= awv_d;
         wv_q    <= wv_d;
         arv_q   <= arv_d;
         err_q   <= err_d;
         ecnt_q  <= ecnt_d;
      end
   end
endmodule

// File: doc/axi4_burst_ptgen.md
AXI4_BURST_PTGEN -- requirements
Module: axi4_burst_ptgen

Interface
REQ-001 Parameter ADDR_W, default 32, AXI address width.
REQ-002 Parameter DATA_W, default 32, AXI data width; allowed values are 32, 64 or 128.
REQ-003 Parameter BURST_LEN, default 16, beats per burst; allowed range is 1..256.
REQ-004 Parameter NUM_BURSTS, default 4, bursts per transaction; allowed range is 1..65535.
REQ-005 Parameter BASE_ADDR, default 32'h4000_0000, first burst address; BURST_LEN*DATA_W/8 must divide 4096, so that no burst crosses a 4 KB boundary.
REQ-006 ACLK  in  1  the single clock; every signal is sampled on its rising edge.
REQ-007 ARESET  in  1  reset; synchronous and active-high.
REQ-008 INIT_AXI_TXN  in  1  transaction start; a rising edge starts a run.
REQ-009 MODE  in  2  run mode: 0 = write then read-compare; 1 = write only; 2 = read-compare only; 3 = treated as 0; sampled at start.
REQ-010 SEED  in  DATA_W  pattern seed; sampled at start.
REQ-011 M_AXI_AWADDR/AWLEN/AWSIZE/AWBURST  out  ADDR_W/8/3/2  write address channel payload.
REQ-012 M_AXI_AWVALID out 1, M_AXI_AWREADY in 1  write address handshake.
REQ-013 M_AXI_WDATA/WSTRB/WLAST  out  DATA_W/DATA_W/8/1  write data channel payload.
REQ-014 M_AXI_WVALID out 1, M_AXI_WREADY in 1  write data handshake.
REQ-015 M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1  write response channel.
REQ-016 M_AXI_ARADDR/ARLEN/ARSIZE/ARBURST  out  ADDR_W/8/3/2  read address channel payload.
REQ-017 M_AXI_ARVALID out 1, M_AXI_ARREADY in 1  read address handshake.
REQ-018 M_AXI_RDATA/RRESP/RLAST in DATA_W/2/1, M_AXI_RVALID in 1, M_AXI_RREADY out 1  read data channel.
REQ-019 TXN_DONE  out  1  run complete; level output.
REQ-020 ERROR  out  1  sticky error flag.
REQ-021 ERR_CNT  out  16  saturating count of error events.
REQ-022 BUSY  out  1  high whenever the state is not IDLE or DONE.

Function
REQ-023 The controller SHALL implement the states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA and DONE, with at most one outstanding burst.
REQ-024 A run SHALL start only on a rising edge of INIT_AXI_TXN detected in IDLE or DONE.
- Edges seen while BUSY are ignored.
- Holding INIT_AXI_TXN high does not retrigger a run.
- At start, TXN_DONE, ERROR and ERR_CNT clear and MODE/SEED are latched.
REQ-025 Write phase (MODE 0, 1 and 3): the sequence WR_ADDR -> WR_DATA -> WR_RESP SHALL repeat per burst.
- After the last burst's B response, the next state is RD_ADDR in MODE 0/3, or DONE in MODE 1.
REQ-026 Read phase (MODE 0, 2 and 3): the sequence RD_ADDR -> RD_DATA SHALL repeat per burst, then go to DONE.
- MODE 2 enters RD_ADDR directly at start.
REQ-027 Burst address b (0-based) SHALL be BASE_ADDR + b*BURST_LEN*(DATA_W/8).
- AxLEN = BURST_LEN-1.
- AxSIZE = log2(DATA_W/8).
- AxBURST = 2'b01 (INCR).
- WSTRB = all ones.
REQ-028 Beat data SHALL equal SEED + global beat index (b*BURST_LEN + beat), truncated modulo 2^DATA_W; the same value is the read expectation.
REQ-029 Every VALID SHALL rise no earlier than one cycle after entering its state.
- Once raised, a VALID and its payload hold stable until the matching READY handshake.
- No VALID depends combinationally on a READY.
REQ-030 WLAST SHALL be asserted only on beat BURST_LEN-1.
REQ-031 BREADY SHALL be high only in WR_RESP; RREADY SHALL be high only in RD_DATA.
REQ-032 Each of the following SHALL be one error event, setting ERROR and incrementing ERR_CNT, which saturates at 16'hFFFF:
- BRESP != 0.
- RRESP != 0.
- RDATA != expected.
- RLAST != (beat == BURST_LEN-1).
- Simultaneous causes on one beat count once.
REQ-033 An error SHALL NOT abort the run; all bursts complete.
REQ-034 In DONE, TXN_DONE SHALL be 1 and remain 1 until the next start or reset.

Reset
REQ-035 While ARESET is 1 at a clock edge, the block SHALL on that edge:
- go to IDLE;
- drive all VALID/READY outputs and TXN_DONE, ERROR, ERR_CNT and BUSY to 0;
- clear the burst and beat counters;
- set the INIT edge detector so that a level already high does not start a run.
REQ-036 A reset asserted mid-burst SHALL abandon the burst with no further handshakes; the run restarts from burst 0 on the next INIT rising edge.

Verification (BURST_LEN=16, NUM_BURSTS=4, DATA_W=32)
REQ-037 MODE=0, SEED=0x100, zero-wait memory slave -> AWADDR 0x40000000/40/80/C0, WDATA 0x100..0x13F, all reads match, TXN_DONE=1, ERROR=0, ERR_CNT=0.
REQ-038 Slave flips RDATA of beat 5 in burst 2 -> ERR_CNT=1, ERROR=1, all 4 read bursts still complete, TXN_DONE=1.
REQ-039 BRESP=2'b10 on burst 0 plus RLAST missing on burst 3 -> ERR_CNT=2, ERROR=1.
REQ-040 Random READY stalls of 0-7 cycles on all channels -> payloads stable while VALID and not READY, results identical to REQ-037.
REQ-041 ARESET pulsed at W beat 7 of burst 1 -> next cycle all VALIDs 0 and TXN_DONE=0; the following INIT edge restarts with AWADDR 0x40000000.
REQ-042 INIT pulse while BUSY, then INIT held high through DONE -> no second run; MODE=2 run afterwards issues 4 AR bursts and no AW.
